// File: rtl/byte_word_assembler_if.sv
// Byte-in / word-out bus of byte_word_assembler.
//   byte_valid_i/byte_data_i/byte_ready_o : upstream byte handshake
//   flush_i                               : request to emit the partial word
//   word_valid_o/word_data_o/word_be_o/word_ready_i : downstream word handshake
//   sel_o                                 : lane of the next accepted byte
//   word_count_o                          : saturating count of handed-off words
// Signal suffixes are relative to the assembler; master is the assembler side,
// slave is the producer/consumer environment.
interface byte_word_assembler_if #(
  parameter int unsigned CNT_W = 16
);
  logic             byte_valid_i;
  logic [7:0]       byte_data_i;
  logic             byte_ready_o;
  logic             flush_i;
  logic             word_valid_o;
  logic [31:0]      word_data_o;
  logic [3:0]       word_be_o;
  logic             word_ready_i;
  logic [1:0]       sel_o;
  logic [CNT_W-1:0] word_count_o;

  modport master (
    input  byte_valid_i, byte_data_i, flush_i, word_ready_i,
    output byte_ready_o, word_valid_o, word_data_o, word_be_o, sel_o, word_count_o
  );

  modport slave (
    output byte_valid_i, byte_data_i, flush_i, word_ready_i,
    input  byte_ready_o, word_valid_o, word_data_o, word_be_o, sel_o, word_count_o
  );
endinterface

// File: rtl/byte_word_assembler.sv
// Packs a byte stream little-endian into 32-bit words (first byte in [7:0]) and
// hands them to a one-word output register. A flush emits a partial word with
// unfilled lanes driven to FILL_VALUE and their byte enables cleared.
//   wb_clk_i : clock, rising edge
//   wb_rst_i : synchronous active-high reset
//   bus      : byte/word handshake bundle (see byte_word_assembler_if)
module byte_word_assembler #(
  parameter int unsigned CNT_W      = 16,
  parameter logic [7:0]  FILL_VALUE = 8'h00
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_i,
  byte_word_assembler_if.master bus
);

  typedef enum logic [0:0] {StAccum, StStall} state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [3:0]       acc_be_q, acc_be_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             wv_q, wv_d;
  logic [31:0]      wd_q, wd_d;
  logic [3:0]       wbe_q, wbe_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        byte_ready;
  logic        accept;
  logic        out_free;
  logic        complete;
  logic [31:0] form_data;
  logic [3:0]  form_be;
  logic        load;
  logic [31:0] load_data;
  logic [3:0]  load_be;

  assign byte_ready = (state_q == StAccum) && !wb_rst_i;
  assign accept     = bus.byte_valid_i && byte_ready;
  assign out_free   = !wv_q || bus.word_ready_i;

  // Word as it stands including the byte accepted this cycle.
  always_comb begin
    form_data = acc_q;
    form_be   = acc_be_q;
    if (accept) begin
      form_data[{ptr_q, 3'b000} +: 8] = bus.byte_data_i;
      form_be[ptr_q]                  = 1'b1;
    end
  end

  assign complete = (state_q == StAccum) &&
                    ((accept && (ptr_q == 2'd3)) ||
                     (bus.flush_i && ((acc_be_q != 4'd0) || accept)));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_be_d  = acc_be_q;
    ptr_d     = ptr_q;
    wv_d      = wv_q;
    wd_d      = wd_q;
    wbe_d     = wbe_q;
    count_d   = count_q;
    load      = 1'b0;
    load_data = form_data;
    load_be   = form_be;

    if (wv_q && bus.word_ready_i) begin
      wv_d = 1'b0;
      if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      StAccum: begin
        if (complete) begin
          ptr_d = 2'd0;
          if (out_free) begin
            load     = 1'b1;
            acc_d    = 32'd0;
            acc_be_d = 4'd0;
          end else begin
            // Park the finished word until the output register frees up.
            acc_d    = form_data;
            acc_be_d = form_be;
            state_d  = StStall;
          end
        end else if (accept) begin
          acc_d    = form_data;
          acc_be_d = form_be;
          ptr_d    = ptr_q + 2'd1;
        end
      end
      StStall: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = acc_q;
          load_be   = acc_be_q;
          acc_d     = 32'd0;
          acc_be_d  = 4'd0;
          state_d   = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase

    if (load) begin
      wv_d  = 1'b1;
      wbe_d = load_be;
      for (int k = 0; k < 4; k++) begin
        wd_d[8*k +: 8] = load_be[k] ? load_data[8*k +: 8] : FILL_VALUE;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StAccum;
      acc_q    <= 32'd0;
      acc_be_q <= 4'd0;
      ptr_q    <= 2'd0;
      wv_q     <= 1'b0;
      wd_q     <= 32'd0;
      wbe_q    <= 4'd0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      acc_be_q <= acc_be_d;
      ptr_q    <= ptr_d;
      wv_q     <= wv_d;
      wd_q     <= wd_d;
      wbe_q    <= wbe_d;
      count_q  <= count_d;
    end
  end

  assign bus.byte_ready_o = byte_ready;
  assign bus.sel_o        = ptr_q;
  assign bus.word_valid_o = wv_q;
  assign bus.word_data_o  = wd_q;
  assign bus.word_be_o    = wbe_q;
  assign bus.word_count_o = count_q;

endmodule

// File: tb/tb_byte_word_assembler.sv
module tb_byte_word_assembler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  byte_word_assembler_if #(.CNT_W(16)) bus ();
  byte_word_assembler_if #(.CNT_W(2))  bus2 ();

  // Second instance with a 2-bit counter sees the same stimulus.
  assign bus2.byte_valid_i = bus.byte_valid_i;
  assign bus2.byte_data_i  = bus.byte_data_i;
  assign bus2.flush_i      = bus.flush_i;
  assign bus2.word_ready_i = bus.word_ready_i;

  byte_word_assembler #(.CNT_W(16), .FILL_VALUE(8'h00)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  byte_word_assembler #(.CNT_W(2), .FILL_VALUE(8'h00)) dut2 (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic r);
    bus.byte_valid_i = v;
    bus.byte_data_i  = d;
    bus.flush_i      = f;
    bus.word_ready_i = r;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        f;
    logic        r;
    logic        e_rdy;
    logic [1:0]  e_sel;
    logic        e_wv;
    logic [31:0] e_wd;
    logic [3:0]  e_be;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Stream 8 bytes back-to-back with the consumer always ready; outputs
    // checked before each edge.
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0, 16'd0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0,        4'h0, 16'd0};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0,        4'h0, 16'd0};
    vecs[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h0,        4'h0, 16'd0};
    vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h44332211, 4'hF, 16'd0};
    vecs[5] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0,        4'h0, 16'd1};
    vecs[6] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0,        4'h0, 16'd1};
    vecs[7] = '{1'b1, 8'h88, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h0,        4'h0, 16'd1};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h88776655, 4'hF, 16'd1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0, 16'd2};

    // Reset held two cycles with a byte offered.
    rst = 1'b1;
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    #1;
    chk("rst_ready", 32'(bus.byte_ready_o), 32'd0);
    tick();
    tick();
    chk("rst_ready2", 32'(bus.byte_ready_o), 32'd0);
    chk("rst_wvalid", 32'(bus.word_valid_o), 32'd0);
    chk("rst_count", 32'(bus.word_count_o), 32'd0);
    chk("rst_sel", 32'(bus.sel_o), 32'd0);
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("post_rst_sel", 32'(bus.sel_o), 32'd0);
    chk("post_rst_wvalid", 32'(bus.word_valid_o), 32'd0);

    // Table-driven streaming.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].f, vecs[i].r);
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(bus.byte_ready_o), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_sel", i), 32'(bus.sel_o), 32'(vecs[i].e_sel));
      chk($sformatf("vec%0d_wvalid", i), 32'(bus.word_valid_o), 32'(vecs[i].e_wv));
      chk($sformatf("vec%0d_count", i), 32'(bus.word_count_o), 32'(vecs[i].e_cnt));
      if (vecs[i].e_wv) begin
        chk($sformatf("vec%0d_data", i), bus.word_data_o, vecs[i].e_wd);
        chk($sformatf("vec%0d_be", i), 32'(bus.word_be_o), 32'(vecs[i].e_be));
      end
      tick();
    end
    chk("small_cnt_2", 32'(bus2.word_count_o), 32'd2);

    // Back-pressure: consumer stalls, second word parks in the accumulator.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'((i + 1) * 8'h11), 1'b0, 1'b0);
      tick();
    end
    chk("stall_ready", 32'(bus.byte_ready_o), 32'd0);
    chk("stall_wvalid", 32'(bus.word_valid_o), 32'd1);
    chk("stall_hold_data", bus.word_data_o, 32'h44332211);
    chk("stall_sel", 32'(bus.sel_o), 32'd0);
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    tick();
    chk("stall_ready_b", 32'(bus.byte_ready_o), 32'd0);
    chk("stall_hold_data_b", bus.word_data_o, 32'h44332211);
    chk("stall_count", 32'(bus.word_count_o), 32'd2);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("unstall_data", bus.word_data_o, 32'h88776655);
    chk("unstall_wvalid", 32'(bus.word_valid_o), 32'd1);
    chk("unstall_ready", 32'(bus.byte_ready_o), 32'd1);
    chk("unstall_count", 32'(bus.word_count_o), 32'd3);
    tick();
    chk("drain_wvalid", 32'(bus.word_valid_o), 32'd0);
    chk("drain_count", 32'(bus.word_count_o), 32'd4);

    // Flush of a two-byte partial word.
    drive(1'b1, 8'hA1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'hB2, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    chk("flush2_wvalid", 32'(bus.word_valid_o), 32'd1);
    chk("flush2_data", bus.word_data_o, 32'h0000B2A1);
    chk("flush2_be", 32'(bus.word_be_o), 32'b0011);
    chk("flush2_sel", 32'(bus.sel_o), 32'd0);
    // Flush together with a byte.
    drive(1'b1, 8'hC3, 1'b1, 1'b1);
    tick();
    chk("flush1_data", bus.word_data_o, 32'h000000C3);
    chk("flush1_be", 32'(bus.word_be_o), 32'b0001);
    chk("flush1_wvalid", 32'(bus.word_valid_o), 32'd1);
    chk("flush1_count", 32'(bus.word_count_o), 32'd5);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("flush_drain_count", 32'(bus.word_count_o), 32'd6);

    // Flush on an empty accumulator emits nothing.
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    chk("empty_flush_wvalid", 32'(bus.word_valid_o), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("empty_flush_wvalid2", 32'(bus.word_valid_o), 32'd0);
    chk("empty_flush_count", 32'(bus.word_count_o), 32'd6);
    chk("small_cnt_sat", 32'(bus2.word_count_o), 32'd3);

    // Reset in the middle of a word discards the partial bytes.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(i + 1), 1'b0, 1'b1);
      tick();
    end
    chk("pre_rst_sel", 32'(bus.sel_o), 32'd3);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    chk("mid_rst_sel", 32'(bus.sel_o), 32'd0);
    chk("mid_rst_count", 32'(bus.word_count_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i + 4), 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clean_wvalid", 32'(bus.word_valid_o), 32'd1);
    chk("clean_data", bus.word_data_o, 32'h07060504);
    chk("clean_be", 32'(bus.word_be_o), 32'hF);
    tick();
    chk("clean_count", 32'(bus.word_count_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_word_assembler.md
Name: byte_word_assembler

Overview:
- Sequential front end for the 32-bit user data path. Accepts a byte stream on a valid/ready handshake and packs bytes little-endian: first byte into [7:0], fourth into [31:24].
- Presents completed words to the downstream consumer through a one-word output register with its own valid/ready handshake.
- Exports the current byte lane as sel_o, using the 2-bit lane-select encoding of the downstream byte-lane decoder.
- Supports flushing a partial word, marked with per-byte enables.

Parameters:
- CNT_W, 16, width of the saturating emitted-word counter.
- FILL_VALUE, 8'h00, value driven on word_data_o lanes whose byte enable is 0.

Ports:
- wb_clk_i  input  1  sole clock; all state updates on rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- byte_valid_i  input  1  upstream byte valid.
- byte_data_i  input  8  upstream byte.
- byte_ready_o  output  1  assembler can accept a byte this cycle.
- flush_i  input  1  single-cycle request to emit the partial word.
- word_valid_o  output  1  output register holds a word.
- word_data_o  output  32  assembled word; lane k = bits [8k+7:8k].
- word_be_o  output  4  byte enables of word_data_o; bit k covers lane k.
- word_ready_i  input  1  downstream accepts the word.
- sel_o  output  2  lane the next accepted byte will occupy (00 = [7:0] … 11 = [31:24]).
- word_count_o  output  CNT_W  words handed off; saturating.

Behaviour:
- Internal state:
  - acc[31:0], acc_be[3:0], ptr[1:0];
  - output register word_valid_o / word_data_o / word_be_o;
  - FSM {ACCUM, STALL}.
- Reset (wb_rst_i=1 at an edge):
  - state=ACCUM; ptr=0; acc=0; acc_be=0.
  - word_valid_o=0, word_data_o=0, word_be_o=0, word_count_o=0.
  - byte_ready_o forced 0 while wb_rst_i is high.
  - Reset mid-operation discards the partial word and any pending output word.
- Derived signals:
  - byte_ready_o = (state==ACCUM) && !wb_rst_i.
  - sel_o = ptr.
  - out_free = !word_valid_o || word_ready_i.
  - accept = byte_valid_i && byte_ready_o.
- ACCUM, on accept:
  - acc[lane ptr] <= byte_data_i; acc_be[ptr] <= 1; ptr <= ptr+1 (wraps 3→0).
- Completion event in ACCUM: (accept && ptr==3), or (flush_i && (acc_be!=0 || accept)).
  - The word formed includes the byte accepted this cycle.
  - Unfilled lanes = FILL_VALUE, their be bits = 0.
- On completion with out_free:
  - Load the word into the output register; word_valid_o=1 next cycle.
  - Clear acc to 0, acc_be to 0, ptr to 0; stay in ACCUM.
- On completion without out_free:
  - Keep the formed word in acc/acc_be; ptr=0; go to STALL.
- STALL:
  - byte_ready_o=0; flush_i ignored.
  - When out_free: move acc/acc_be into the output register, clear acc, return to ACCUM.
- Flush corner cases:
  - flush_i with acc_be==0 and no accept is ignored; no empty word is ever emitted.
- Output register:
  - Holds stable while word_valid_o && !word_ready_i.
  - On handshake with no new load, word_valid_o=0 next cycle.
  - Handshake and new load in the same cycle (back-to-back) keeps word_valid_o=1 with the new contents.
- word_count_o increments on word_valid_o && word_ready_i; saturates at all-ones.
- Latency and throughput:
  - 4th byte accepted at edge N → word visible after edge N.
  - Sustained 1 byte/cycle when word_ready_i is held 1.
  - A STALL costs at least one byte-cycle.

Test Plan:
- Reset: assert wb_rst_i 2 cycles with byte_valid_i=1 → byte_ready_o=0, word_valid_o=0, word_count_o=0, sel_o=00; no byte accepted.
- Stream 11,22,33,44,55,66,77,88 back-to-back, word_ready_i=1 → words 32'h44332211 then 32'h88776655, be=4'hF, sel_o cycles 00,01,10,11, byte_ready_o never drops, word_count_o=2.
- Hold word_ready_i=0 after the first word; send 8 bytes → second word completes, FSM enters STALL, byte_ready_o=0, word_data_o stays 32'h44332211. Raise word_ready_i → 32'h88776655 follows next cycle, byte_ready_o returns to 1.
- Send A1,B2, then flush_i alone → word_data_o=32'h0000B2A1, word_be_o=4'b0011, ptr resets to 00. Send C3 with flush_i in the same cycle → 32'h000000C3, be 4'b0001.
- flush_i with empty accumulator, no byte → no word emitted, count unchanged. Assert wb_rst_i after 3 bytes → partial data lost; next 4 bytes form a clean word.
- With CNT_W=2, hand off 5 words → word_count_o saturates at 3.
